// File: rtl/lif_timestep_scheduler_if.sv
// Bundle of step-control, weight-memory and spike-event signals for the LIF timestep scheduler.
// master = scheduler side, slave = surrounding sequencer / weight memory / spike router.
interface lif_timestep_scheduler_if #(
  parameter int IDX_W = 4
);
  logic             step_start;
  logic [7:0]       spike_in;
  logic [7:0]       threshold;
  logic [7:0]       leak_value;
  logic [3:0]       tref;
  logic             step_busy;
  logic             step_done;
  logic             w_rd;
  logic [IDX_W-1:0] w_addr;
  logic [63:0]      w_data;
  logic             ev_valid;
  logic [IDX_W-1:0] ev_idx;
  logic             ev_ready;

  modport master (
    input  step_start, spike_in, threshold, leak_value, tref, w_data, ev_ready,
    output step_busy, step_done, w_rd, w_addr, ev_valid, ev_idx
  );

  modport slave (
    output step_start, spike_in, threshold, leak_value, tref, w_data, ev_ready,
    input  step_busy, step_done, w_rd, w_addr, ev_valid, ev_idx
  );
endinterface

// File: rtl/lif_timestep_scheduler.sv
// Time-multiplexed LIF neuron controller: one shared integrate/leak/threshold unit per timestep.
// Optional refractory storage is built only when LIF_REFRACTORY_EN is defined.
module lif_timestep_scheduler #(
  parameter int NUM_NEURONS = 16,
  parameter int IDX_W       = 4
) (
  input logic                     clk,
  input logic                     reset_n,
  lif_timestep_scheduler_if.master bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_UPDATE = 3'd2;
  localparam logic [2:0] ST_EMIT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] ev_idx_r;
  logic [7:0]       spike_s;
  logic [7:0]       thr_s;
  logic [7:0]       leak_s;
  logic [7:0]       v_mem [NUM_NEURONS];

  logic [11:0]      s_sum;
  logic [11:0]      l_val;
  logic             underflow;
  logic             fire;
  logic [7:0]       v_next;
  logic [3:0]       tr_cur;
  logic [3:0]       tr_next;
  logic             last;

  function automatic logic [11:0] syn_sum(input logic [7:0] spk, input logic [63:0] lanes);
    logic [11:0] acc;
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      if (spk[k]) acc = acc + {4'd0, lanes[8*k +: 8]};
    end
    return acc;
  endfunction

`ifdef LIF_REFRACTORY_EN
  logic [3:0] tref_s;
  logic [3:0] tr_mem [NUM_NEURONS];

  assign tr_cur = tr_mem[idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tref_s <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) tr_mem[n] <= '0;
    end else begin
      if (state == ST_IDLE && bus.step_start) tref_s <= bus.tref;
      if (state == ST_UPDATE) tr_mem[idx] <= tr_next;
    end
  end
`else
  // No refractory storage: every neuron is always eligible to fire.
  assign tr_cur = 4'd0;
`endif

  // Integrate / leak / threshold for the neuron whose weights arrive this cycle.
  always_comb begin
    s_sum     = {4'd0, v_mem[idx]} + syn_sum(spike_s, bus.w_data);
    underflow = s_sum < {4'd0, leak_s};
    l_val     = s_sum - {4'd0, leak_s};
    fire      = 1'b0;
    v_next    = 8'd0;
    tr_next   = tr_cur;
    if (tr_cur != 4'd0) begin
      tr_next = tr_cur - 4'd1;
    end else if (underflow) begin
      v_next = 8'd0;
    end else if (l_val >= {4'd0, thr_s}) begin
      fire = 1'b1;
`ifdef LIF_REFRACTORY_EN
      tr_next = tref_s;
`endif
    end else begin
      v_next = l_val[7:0];
    end
  end

  assign last = (idx == IDX_W'(NUM_NEURONS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      ev_idx_r <= '0;
      spike_s  <= '0;
      thr_s    <= '0;
      leak_s   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.step_start) begin
            spike_s <= bus.spike_in;
            thr_s   <= bus.threshold;
            leak_s  <= bus.leak_value;
            idx     <= '0;
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_UPDATE;
        ST_UPDATE: begin
          if (fire) begin
            ev_idx_r <= idx;
            state    <= ST_EMIT;
          end else if (last) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= ST_FETCH;
          end
        end
        ST_EMIT: begin
          if (bus.ev_ready) begin
            if (last) begin
              state <= ST_DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_NEURONS; n++) v_mem[n] <= '0;
    end else if (state == ST_UPDATE) begin
      v_mem[idx] <= v_next;
    end
  end

  assign bus.step_busy = (state != ST_IDLE);
  assign bus.step_done = (state == ST_DONE);
  assign bus.w_rd      = (state == ST_FETCH);
  assign bus.w_addr    = idx;
  assign bus.ev_valid  = (state == ST_EMIT);
  assign bus.ev_idx    = ev_idx_r;

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// Directed self-checking bench for lif_timestep_scheduler (16 neurons).
// Expected refractory behaviour follows LIF_REFRACTORY_EN when the bench is built with it.
module tb_lif_timestep_scheduler;

  localparam int N = 16;
`ifdef LIF_REFRACTORY_EN
  localparam bit REFR = 1'b1;
`else
  localparam bit REFR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  lif_timestep_scheduler_if #(.IDX_W(4)) bus ();

  lif_timestep_scheduler #(.NUM_NEURONS(N), .IDX_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] wmem [N];
  int          done_cnt = 0;
  int          rd_cnt   = 0;
  int          ev_q [$];

  // Weight memory: one-cycle registered read.
  always @(posedge clk) begin
    if (bus.w_rd) bus.w_data <= wmem[bus.w_addr];
  end

  always @(posedge clk) begin
    if (bus.ev_valid && bus.ev_ready) ev_q.push_back(int'(bus.ev_idx));
    if (bus.step_done) done_cnt <= done_cnt + 1;
    if (bus.w_rd) rd_cnt <= rd_cnt + 1;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_step(input logic [7:0] sp, input logic [7:0] thr, input logic [7:0] lk,
                          input logic [3:0] tr, output int cyc, output int busy1,
                          output int nev, output int nrd);
    int ev0, rd0;
    @(negedge clk);
    bus.spike_in = sp; bus.threshold = thr; bus.leak_value = lk; bus.tref = tr;
    bus.step_start = 1'b1;
    ev0 = ev_q.size();
    rd0 = rd_cnt;
    @(negedge clk);
    bus.step_start = 1'b0;
    busy1 = int'(bus.step_busy);
    cyc = 1;
    while (!bus.step_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.step_done) cyc = -1;
    @(negedge clk);
    nev = ev_q.size() - ev0;
    nrd = rd_cnt - rd0;
  endtask

  int cyc, busy1, nev, nrd, d0, ev0, waited, stable, bad;
  int exp_v [3];

  initial begin
    reset_n = 1'b0;
    bus.step_start = 1'b0; bus.spike_in = '0; bus.threshold = '0;
    bus.leak_value = '0; bus.tref = '0; bus.ev_ready = 1'b1;
    for (int i = 0; i < N; i++) wmem[i] = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy",  int'(bus.step_busy), 0);
    check_val("rst_done",  int'(bus.step_done), 0);
    check_val("rst_w_rd",  int'(bus.w_rd), 0);
    check_val("rst_waddr", int'(bus.w_addr), 0);
    check_val("rst_evv",   int'(bus.ev_valid), 0);
    check_val("rst_evidx", int'(bus.ev_idx), 0);
    reset_n = 1'b1;

    // Reset while an event is held pending.
    bus.ev_ready = 1'b0;
    @(negedge clk);
    bus.spike_in = 8'h01; bus.threshold = 8'd0; bus.leak_value = 8'd0; bus.tref = 4'd0;
    bus.step_start = 1'b1;
    @(negedge clk);
    bus.step_start = 1'b0;
    waited = 0;
    while (!bus.ev_valid && waited < 20) begin @(negedge clk); waited++; end
    check_val("pend_valid", int'(bus.ev_valid), 1);
    check_val("pend_idx", int'(bus.ev_idx), 0);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check_val("abort_busy", int'(bus.step_busy), 0);
    check_val("abort_evv", int'(bus.ev_valid), 0);
    check_val("abort_done", int'(bus.step_done), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus.ev_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("abort_no_done", done_cnt - d0, 0);
    check_val("abort_idle_evv", int'(bus.ev_valid), 0);

    // Quiet step: no spikes, threshold 255.
    run_step(8'h00, 8'd255, 8'd0, 4'd0, cyc, busy1, nev, nrd);
    check_val("quiet_done_cyc", cyc, 2*N+1);
    check_val("quiet_busy_c1", busy1, 1);
    check_val("quiet_events", nev, 0);
    check_val("quiet_w_rd", nrd, N);

    // Accumulation on neuron 3: 40 in, 10 leak, threshold 100.
    wmem[3] = 64'd40;
    for (int s = 1; s <= 3; s++) begin
      run_step(8'h01, 8'd100, 8'd10, 4'd2, cyc, busy1, nev, nrd);
      check_val($sformatf("acc_v3_s%0d", s), int'(dut.v_mem[3]), 30*s);
      check_val($sformatf("acc_ev_s%0d", s), nev, 0);
    end
    ev0 = ev_q.size();
    run_step(8'h01, 8'd100, 8'd10, 4'd2, cyc, busy1, nev, nrd);
    check_val("fire_events", nev, 1);
    check_val("fire_idx", (nev == 1) ? ev_q[ev0] : -1, 3);
    check_val("fire_v3", int'(dut.v_mem[3]), 0);
    check_val("fire_done_cyc", cyc, 2*N+2);

    // Steps after the spike: refractory hold or immediate re-accumulation.
    exp_v[0] = REFR ? 0 : 30;
    exp_v[1] = REFR ? 0 : 60;
    exp_v[2] = REFR ? 30 : 90;
    for (int s = 0; s < 3; s++) begin
      run_step(8'h01, 8'd100, 8'd10, 4'd2, cyc, busy1, nev, nrd);
      check_val($sformatf("refr_v3_s%0d", s+1), int'(dut.v_mem[3]), exp_v[s]);
      check_val($sformatf("refr_ev_s%0d", s+1), nev, 0);
    end

    // Underflow: bring V[3] to 5, then leak 20 with no input.
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    wmem[3] = 64'd15;
    run_step(8'h01, 8'd100, 8'd10, 4'd0, cyc, busy1, nev, nrd);
    check_val("uf_setup_v3", int'(dut.v_mem[3]), 5);
    run_step(8'h00, 8'd100, 8'd20, 4'd0, cyc, busy1, nev, nrd);
    check_val("uf_v3", int'(dut.v_mem[3]), 0);
    check_val("uf_events", nev, 0);

    // Backpressure: every neuron fires, ready held low 5 cycles per event.
    wmem[3] = 64'd0;
    bus.ev_ready = 1'b0;
    d0 = done_cnt;
    ev0 = ev_q.size();
    @(negedge clk);
    bus.spike_in = 8'h00; bus.threshold = 8'd0; bus.leak_value = 8'd0; bus.tref = 4'd0;
    bus.step_start = 1'b1;
    @(negedge clk);
    bus.step_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      waited = 0;
      while (!bus.ev_valid && waited < 50) begin @(negedge clk); waited++; end
      if (!bus.ev_valid) begin
        check_val($sformatf("bp_timeout_%0d", i), 0, 1);
        break;
      end
      check_val($sformatf("bp_idx_%0d", i), int'(bus.ev_idx), i);
      stable = 1;
      repeat (5) begin
        @(negedge clk);
        if (!(bus.ev_valid && int'(bus.ev_idx) == i)) stable = 0;
      end
      check_val($sformatf("bp_hold_%0d", i), stable, 1);
      bus.ev_ready = 1'b1;
      @(negedge clk);
      bus.ev_ready = 1'b0;
    end
    waited = 0;
    while (!bus.step_done && waited < 50) begin @(negedge clk); waited++; end
    check_val("bp_done_seen", int'(bus.step_done), 1);
    @(negedge clk);
    check_val("bp_count", ev_q.size() - ev0, N);
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (ev0 + i >= ev_q.size() || ev_q[ev0+i] != i) bad++;
    end
    check_val("bp_order", bad, 0);
    check_val("bp_done_cnt", done_cnt - d0, 1);
    bus.ev_ready = 1'b1;

    // Start pulse while busy must be dropped.
    d0 = done_cnt;
    ev0 = ev_q.size();
    @(negedge clk);
    bus.spike_in = 8'h00; bus.threshold = 8'd255; bus.leak_value = 8'd0;
    bus.step_start = 1'b1;
    @(negedge clk);
    bus.step_start = 1'b0;
    cyc = 1;
    repeat (3) begin @(negedge clk); cyc++; end
    bus.step_start = 1'b1; bus.threshold = 8'd0;
    @(negedge clk); cyc++;
    bus.step_start = 1'b0;
    while (!bus.step_done && cyc < 300) begin @(negedge clk); cyc++; end
    check_val("busy_done_cyc", bus.step_done ? cyc : -1, 2*N+1);
    repeat (40) @(negedge clk);
    check_val("busy_one_done", done_cnt - d0, 1);
    check_val("busy_thr_kept", ev_q.size() - ev0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
